writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Parametrised M→W pipeline register and writeback-result generator for the MIPS pipeline.
- Adds the following over a plain M/W register:
  - a valid bit;
  - stall and flush control;
  - sub-word load extraction with sign/zero extension;
  - misalignment detection;
  - $zero write suppression;
  - a retired-instruction counter.
- Sits between the memory stage and the register file; its outputs also feed the hazard/forwarding unit.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall_w  input  1  hold all W registers.
- flush_w  input  1  load a bubble into W.
- valid_m  input  1  M-stage instruction is valid.
- reg_write_m  input  1  instruction writes the register file.
- mem_to_reg_m  input  1  result comes from memory, not the ALU.
- load_size_m  input  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- load_signed_m  input  1  sign-extend a sub-word load.
- alu_out_m  input  DATA_W  ALU result; its low bits are the byte address.
- read_data_m  input  DATA_W  naturally aligned memory word.
- write_reg_m  input  REG_ADDR_W  destination register.
- result_w  output  DATA_W  writeback data.
- write_reg_w  output  REG_ADDR_W  destination register.
- reg_write_w  output  1  register-file write enable (qualified).
- valid_w  output  1  W holds a valid instruction.
- misalign_w  output  1  W holds a misaligned load.
- retired_cnt  output  CNT_W  count of instructions captured into W.

Behaviour:
- **Reset:** asynchronous, active-high. While rst=1, every output is 0: result_w, write_reg_w, reg_write_w, valid_w, misalign_w, retired_cnt.
- **Latency:** 1 cycle. M-stage values presented before edge N appear on the W outputs after edge N.
- **Priority at each rising edge:** flush_w > stall_w > normal capture.
- **Flush:**
  - valid_w, reg_write_w and misalign_w go to 0.
  - result_w and write_reg_w keep their old values; they are don't-care while the stage holds a bubble.
  - retired_cnt does not increment.
- **Stall without flush:** all registers hold, including retired_cnt.
- **Normal capture:**
  - valid_w ← valid_m.
  - write_reg_w ← write_reg_m.
  - result_w ← ext when mem_to_reg_m=1, otherwise alu_out_m.
  - misalign_w ← valid_m & mem_to_reg_m & mis.
  - reg_write_w ← valid_m & reg_write_m & (write_reg_m ≠ 0) & ~(mem_to_reg_m & mis).
  - retired_cnt increments by 1 when valid_m=1. It wraps modulo 2^CNT_W.
- **Load extraction (combinational, before the register):**
  - Offset off = alu_out_m[OFF_W-1:0], where OFF_W = $clog2(DATA_W/8).
  - Byte: lane = read_data_m[8·off +: 8].
  - Half: lane = read_data_m[16·off[OFF_W-1:1] +: 16].
  - Word: for DATA_W=64, lane = read_data_m[32·off[2] +: 32]; for DATA_W=32, lane = the whole read_data_m.
  - Dword: legal only when DATA_W=64, where lane = read_data_m. When DATA_W=32, dword is treated as word.
  - ext = lane sign-extended when load_signed_m=1, otherwise zero-extended, to DATA_W. A full-width load needs no extension.
- **Misalignment (mis):**
  - Half: off[0] ≠ 0.
  - Word: off[1:0] ≠ 0.
  - Dword: off ≠ 0.
  - Byte loads are never misaligned.
  - On a misaligned load, result_w is still captured as computed (don't-care) and no register write occurs.
- **Non-load instructions:** load_size_m and load_signed_m are ignored, and mis is not evaluated.
- **Reset mid-operation:** takes effect immediately, without waiting for a clock edge. The first capture happens on the first edge after rst deasserts.

Decomposition:
- Package wb_pkg:
  - load_size_e enum (LS_BYTE=0, LS_HALF=1, LS_WORD=2, LS_DWORD=3);
  - function off_w(DATA_W) returning $clog2(DATA_W/8).
- One combinational sub-module, load_align.
  - Parameter: DATA_W.
  - Inputs: read_data, off, size, signed.
  - Outputs: ext, mis.
- writeback_stage owns the register, the qualification logic and the counter.

Test Plan:
- **Reset, then plain capture:** rst pulse, then valid_m=1, reg_write_m=1, mem_to_reg_m=0, alu_out_m=0x1234_5678, write_reg_m=8 → next cycle result_w=0x12345678, write_reg_w=8, reg_write_w=1, valid_w=1, retired_cnt=1.
- **Sub-word loads (DATA_W=32), read_data_m=0x80FF_7F01:**
  - byte, signed, off=3 → result_w=0xFFFFFF80;
  - byte, unsigned, off=3 → 0x00000080;
  - half, signed, off=2 → 0xFFFF80FF;
  - half, unsigned, off=0 → 0x00007F01;
  - word, off=0 → 0x80FF7F01.
- **Misalignment:** word load with off=2, reg_write_m=1 → misalign_w=1, reg_write_w=0, valid_w=1, retired_cnt increments.
- **$zero suppression:** reg_write_m=1, write_reg_m=0 → reg_write_w=0, valid_w=1.
- **Stall/flush priority:**
  - stall_w=1 for 3 cycles with changing M inputs → outputs and retired_cnt frozen.
  - stall_w=1 and flush_w=1 together → valid_w=0, reg_write_w=0, retired_cnt unchanged.
- **DATA_W=64 and counter wrap:**
  - read_data_m=0x8000_0001_0000_0002, signed word load, off=4 → 0xFFFFFFFF80000001.
  - With CNT_W=4, 17 valid captures → retired_cnt=1.
  - Assert rst asynchronously between clock edges → all outputs read 0 before the next edge.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the writeback stage
package wb_pkg;

    typedef enum logic [1:0] {
        LS_BYTE  = 2'd0,
        LS_HALF  = 2'd1,
        LS_WORD  = 2'd2,
        LS_DWORD = 2'd3
    } load_size_e;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - sub-word load lane extraction, extension and misalignment check
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = off_w(DATA_W)
) (
    input  logic [DATA_W-1:0] read_data,
    input  logic [OFF_W-1:0]  off,
    input  load_size_e        size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] ext,
    output logic              mis
);

    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_h;
    logic [DATA_W-1:0] sh_w;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    load_size_e         sz;

    assign sh_b = read_data >> {off, 3'b000};
    assign sh_h = read_data >> {off[OFF_W-1:1], 4'b0000};

    // A 32-bit datapath has no dword lane, so a dword request degrades to a word.
    generate
        if (DATA_W == 64) begin : g_w64
            assign sh_w = read_data >> {off[OFF_W-1], 5'b00000};
            assign sz   = size;
        end else begin : g_w32
            assign sh_w = read_data;
            assign sz   = (size == LS_DWORD) ? LS_WORD : size;
        end
    endgenerate

    assign b_s = sh_b[7:0];
    assign h_s = sh_h[15:0];
    assign w_s = sh_w[31:0];

    always_comb begin
        ext = read_data;
        mis = 1'b0;
        unique case (sz)
            LS_BYTE: begin
                ext = is_signed ? DATA_W'(b_s) : DATA_W'(sh_b[7:0]);
            end
            LS_HALF: begin
                ext = is_signed ? DATA_W'(h_s) : DATA_W'(sh_h[15:0]);
                mis = off[0];
            end
            LS_WORD: begin
                ext = is_signed ? DATA_W'(w_s) : DATA_W'(sh_w[31:0]);
                mis = (off[1:0] != 2'b00);
            end
            LS_DWORD: begin
                ext = read_data;
                mis = (off != '0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - M/W pipeline register with load alignment, write qualification and retire counter
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic                  valid_m,
    input  logic                  reg_write_m,
    input  logic                  mem_to_reg_m,
    input  logic [1:0]            load_size_m,
    input  logic                  load_signed_m,
    input  logic [DATA_W-1:0]     alu_out_m,
    input  logic [DATA_W-1:0]     read_data_m,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    output logic [DATA_W-1:0]     result_w,
    output logic [REG_ADDR_W-1:0] write_reg_w,
    output logic                  reg_write_w,
    output logic                  valid_w,
    output logic                  misalign_w,
    output logic [CNT_W-1:0]      retired_cnt
);

    localparam int OFF_W = off_w(DATA_W);

    logic [DATA_W-1:0] ext;
    logic              mis;
    logic              load_mis;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .read_data (read_data_m),
        .off       (alu_out_m[OFF_W-1:0]),
        .size      (load_size_e'(load_size_m)),
        .is_signed (load_signed_m),
        .ext       (ext),
        .mis       (mis)
    );

    // Misalignment only matters for loads; ALU results never fault.
    assign load_mis = mem_to_reg_m & mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_w    <= '0;
            write_reg_w <= '0;
            reg_write_w <= 1'b0;
            valid_w     <= 1'b0;
            misalign_w  <= 1'b0;
            retired_cnt <= '0;
        end else if (flush_w) begin
            reg_write_w <= 1'b0;
            valid_w     <= 1'b0;
            misalign_w  <= 1'b0;
        end else if (!stall_w) begin
            result_w    <= mem_to_reg_m ? ext : alu_out_m;
            write_reg_w <= write_reg_m;
            valid_w     <= valid_m;
            misalign_w  <= valid_m & load_mis;
            reg_write_w <= valid_m & reg_write_m & (write_reg_m != '0) & ~load_mis;
            if (valid_m) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule
